// File: rtl/if_stage_pkg.sv
// Widths, reset vector and record types shared by the fetch stage and its neighbours.
// Bus layouts: br_bus = {taken, target}, fs_to_ds_bus = {inst, pc}.
package if_stage_pkg;

   localparam int          BR_BUS_WD       = 33;
   localparam int          FS_TO_DS_BUS_WD = 64;
   localparam logic [31:0] RESET_VECTOR    = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD
   } fs_state_e;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
   } br_bus_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fs_entry_t;

endpackage

// File: rtl/fs_inst_buf.sv
// One-entry skid buffer for a returned instruction that could not enter the fetch slot.
// flush wins over push; push with pop replaces the entry.
module fs_inst_buf
   import if_stage_pkg::*;
(
   input  logic      clk,
   input  logic      resetn,
   input  logic      flush_i,
   input  logic      push_i,
   input  logic      pop_i,
   input  fs_entry_t entry_i,
   output logic      valid_o,
   output logic      valid_nxt_o,
   output fs_entry_t entry_o
);

   logic      valid_q, valid_d;
   fs_entry_t entry_q;

   always_comb begin
      valid_d = valid_q;
      if (flush_i)     valid_d = 1'b0;
      else if (push_i) valid_d = 1'b1;
      else if (pop_i)  valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) valid_q <= 1'b0;
      else         valid_q <= valid_d;
   end

   // NOTE: only the valid bit is reset; the payload is never read while invalid.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) entry_q <= entry_i;
   end

   assign valid_o     = valid_q;
   assign valid_nxt_o = valid_d;
   assign entry_o     = entry_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one-outstanding request FSM, PC sequencing with a branch
// delay slot, one fetch slot toward decode and a one-entry overflow buffer.
module if_stage
   import if_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       ds_allowin,
   input  logic [BR_BUS_WD-1:0]       br_bus,
   output logic                       fs_to_ds_valid,
   output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
   output logic                       inst_sram_req,
   output logic [31:0]                inst_sram_addr,
   input  logic                       inst_sram_addr_ok,
   input  logic                       inst_sram_data_ok,
   input  logic [31:0]                inst_sram_rdata
);

   fs_state_e   state_q, state_d;
   logic [31:0] nxt_pc_q, nxt_pc_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] target_q, target_d;
   logic        cancel_q, cancel_d;
   logic        drop_q, drop_d;
   logic        pend_q, pend_d;
   logic        tgt_next_q, tgt_next_d;
   logic        seen_q, seen_d;
   logic        fs_valid_q, fs_valid_d;
   fs_entry_t   fs_q, fs_d;

   br_bus_t     br;
   fs_entry_t   rdata_entry, buf_entry;
   logic        req_acc, dok, keep, fs_go, br_new, br_flush;
   logic        buf_push, buf_pop, buf_valid, buf_valid_nxt;

   assign br          = br_bus;
   assign rdata_entry = '{inst: inst_sram_rdata, pc: out_pc_q};

   assign inst_sram_req  = resetn && (state_q == S_REQ);
   assign inst_sram_addr = nxt_pc_q;
   assign req_acc        = inst_sram_req && inst_sram_addr_ok;
   assign dok            = inst_sram_data_ok && (state_q == S_WAIT);
   assign fs_go          = fs_valid_q && ds_allowin;
   // seen_q holds off a branch that decode keeps asserting until its delay slot departs
   assign br_new         = br.taken && !pend_q && !seen_q;
   assign br_flush       = br_new && fs_valid_q;
   assign keep           = dok && !cancel_q && !br_flush;

   fs_inst_buf u_buf (
      .clk         (clk),
      .resetn      (resetn),
      .flush_i     (br_flush),
      .push_i      (buf_push),
      .pop_i       (buf_pop),
      .entry_i     (rdata_entry),
      .valid_o     (buf_valid),
      .valid_nxt_o (buf_valid_nxt),
      .entry_o     (buf_entry)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      fs_valid_d = fs_valid_q;
      fs_d       = fs_q;
      buf_push   = 1'b0;
      buf_pop    = 1'b0;
      if (br_flush) begin
         fs_valid_d = !fs_go;
      end else begin
         if (fs_go) begin
            if (buf_valid) begin
               fs_d    = buf_entry;
               buf_pop = 1'b1;
            end else begin
               fs_valid_d = 1'b0;
            end
         end
         if (keep) begin
            if (!fs_valid_q || (fs_go && !buf_valid)) begin
               fs_valid_d = 1'b1;
               fs_d       = rdata_entry;
            end else begin
               buf_push = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      nxt_pc_d   = nxt_pc_q;
      out_pc_d   = out_pc_q;
      target_d   = target_q;
      cancel_d   = cancel_q;
      drop_d     = drop_q;
      pend_d     = pend_q;
      tgt_next_d = tgt_next_q;
      seen_d     = seen_q;

      case (state_q)
         S_REQ:   if (req_acc) state_d = S_WAIT;
         S_WAIT:  if (dok) state_d = buf_valid_nxt ? S_HOLD : S_REQ;
         S_HOLD:  if (!buf_valid_nxt) state_d = S_REQ;
         default: state_d = S_REQ;
      endcase

      if (req_acc) begin
         out_pc_d = nxt_pc_q;
         cancel_d = drop_q;
         drop_d   = 1'b0;
         if (pend_q && !tgt_next_q) begin
            nxt_pc_d   = target_q;
            tgt_next_d = 1'b1;
         end else begin
            nxt_pc_d = nxt_pc_q + 32'd4;
            if (pend_q) begin
               pend_d     = 1'b0;
               tgt_next_d = 1'b0;
            end
         end
      end

      if (dok && cancel_q) cancel_d = 1'b0;
      if (fs_go)           seen_d   = 1'b0;

      if (br_new) begin
         pend_d   = 1'b1;
         target_d = br.target;
         seen_d   = !fs_go;
         // An address already on the bus must stay put; redirect once it is accepted.
         if ((state_q == S_REQ) && !req_acc) begin
            tgt_next_d = 1'b0;
            drop_d     = fs_valid_q;
         end else begin
            nxt_pc_d   = br.target;
            tgt_next_d = 1'b1;
         end
         if (br_flush && (req_acc || ((state_q == S_WAIT) && !dok))) cancel_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_REQ;
         nxt_pc_q   <= RESET_VECTOR;
         cancel_q   <= 1'b0;
         drop_q     <= 1'b0;
         pend_q     <= 1'b0;
         tgt_next_q <= 1'b0;
         seen_q     <= 1'b0;
         fs_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         nxt_pc_q   <= nxt_pc_d;
         cancel_q   <= cancel_d;
         drop_q     <= drop_d;
         pend_q     <= pend_d;
         tgt_next_q <= tgt_next_d;
         seen_q     <= seen_d;
         fs_valid_q <= fs_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      fs_q     <= fs_d;
      out_pc_q <= out_pc_d;
      target_q <= target_d;
   end

   assign fs_to_ds_valid = fs_valid_q;
   assign fs_to_ds_bus   = fs_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a per-cycle vector table for the main flow, then
// hand-written sequences for branch-with-empty-slot, held branch and mid-transaction reset.
module tb_if_stage;
   import if_stage_pkg::*;

   localparam logic [31:0] D = 32'hBFC0_0000;

   logic                       clk = 1'b0;
   logic                       resetn;
   logic                       ds_allowin;
   logic [BR_BUS_WD-1:0]       br_bus;
   logic                       fs_to_ds_valid;
   logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
   logic                       inst_sram_req;
   logic [31:0]                inst_sram_addr;
   logic                       inst_sram_addr_ok;
   logic                       inst_sram_data_ok;
   logic [31:0]                inst_sram_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   logic        watch_en = 1'b0;
   int          good_cnt = 0;
   int          bad_cnt  = 0;

   if_stage dut (
      .clk               (clk),
      .resetn            (resetn),
      .ds_allowin        (ds_allowin),
      .br_bus            (br_bus),
      .fs_to_ds_valid    (fs_to_ds_valid),
      .fs_to_ds_bus      (fs_to_ds_bus),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata)
   );

   always #5 clk = ~clk;

   // Count accepted requests to the held-branch target and to the later, ignored target.
   always @(posedge clk) begin
      if (watch_en && inst_sram_req && inst_sram_addr_ok) begin
         if (inst_sram_addr == D + 32'h300) good_cnt++;
         if (inst_sram_addr == D + 32'h400) bad_cnt++;
      end
   end

   typedef struct packed {
      logic        allow;
      logic        br;
      logic [31:0] tgt;
      logic        aok;
      logic        dok;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   vec_t vecs [0:15];

   function automatic vec_t mk(input logic a, input logic b, input logic [31:0] t,
                               input logic ao, input logic dk, input logic [31:0] rd,
                               input logic er, input logic [31:0] ea, input logic ev,
                               input logic [31:0] ep, input logic [31:0] ei);
      vec_t v;
      v.allow = a;  v.br = b;  v.tgt = t;  v.aok = ao;  v.dok = dk;  v.rdata = rd;
      v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_inst = ei;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic a, input logic b, input logic [31:0] t,
                         input logic ao, input logic dk, input logic [31:0] rd);
      ds_allowin        = a;
      br_bus            = {b, t};
      inst_sram_addr_ok = ao;
      inst_sram_data_ok = dk;
      inst_sram_rdata   = rd;
   endtask

   task automatic cyc(input logic a, input logic b, input logic [31:0] t,
                      input logic ao, input logic dk, input logic [31:0] rd);
      @(negedge clk);
      set_in(a, b, t, ao, dk, rd);
      #1;
   endtask

   task automatic chk_slot(input string name, input logic [31:0] pc, input logic [31:0] inst);
      check({name, "_valid"}, 64'(fs_to_ds_valid), 64'd1);
      check({name, "_bus"}, fs_to_ds_bus, {inst, pc});
   endtask

   task automatic chk_req(input string name, input logic [31:0] addr);
      check({name, "_req"}, 64'(inst_sram_req), 64'd1);
      check({name, "_addr"}, 64'(inst_sram_addr), 64'(addr));
   endtask

   initial begin
      //          allow br tgt        aok dok rdata         | req addr     valid pc       inst
      vecs[0]  = mk(1, 0, 0,         1, 0, 0,              1, D,         0, 0,       0);
      vecs[1]  = mk(1, 0, 0,         0, 1, 32'h2401_0001,  0, 0,         0, 0,       0);
      vecs[2]  = mk(0, 0, 0,         1, 0, 0,              1, D+4,       1, D,       32'h2401_0001);
      vecs[3]  = mk(0, 0, 0,         0, 1, 32'h2402_0002,  0, 0,         1, D,       32'h2401_0001);
      vecs[4]  = mk(0, 0, 0,         0, 0, 0,              0, 0,         1, D,       32'h2401_0001);
      vecs[5]  = mk(0, 0, 0,         0, 0, 0,              0, 0,         1, D,       32'h2401_0001);
      vecs[6]  = mk(0, 0, 0,         0, 0, 0,              0, 0,         1, D,       32'h2401_0001);
      vecs[7]  = mk(1, 0, 0,         0, 0, 0,              0, 0,         1, D,       32'h2401_0001);
      vecs[8]  = mk(1, 0, 0,         1, 0, 0,              1, D+8,       1, D+4,     32'h2402_0002);
      vecs[9]  = mk(1, 0, 0,         0, 1, 32'h2403_0003,  0, 0,         0, 0,       0);
      vecs[10] = mk(0, 0, 0,         1, 0, 0,              1, D+32'hC,   1, D+8,     32'h2403_0003);
      vecs[11] = mk(1, 1, D+32'h100, 0, 0, 0,              0, 0,         1, D+8,     32'h2403_0003);
      vecs[12] = mk(1, 0, 0,         0, 1, 32'hDEAD_BEEF,  0, 0,         0, 0,       0);
      vecs[13] = mk(1, 0, 0,         1, 0, 0,              1, D+32'h100, 0, 0,       0);
      vecs[14] = mk(1, 0, 0,         0, 1, 32'h2404_0004,  0, 0,         0, 0,       0);
      vecs[15] = mk(0, 0, 0,         0, 0, 0,              1, D+32'h104, 1, D+32'h100, 32'h2404_0004);

      resetn = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      check("rst_valid", 64'(fs_to_ds_valid), 64'd0);
      check("rst_req", 64'(inst_sram_req), 64'd0);

      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk_req("rst_first", D);

      // Main flow: first fetch, decode stall into HOLD, branch with delay slot in the slot.
      for (int i = 0; i < 16; i++) begin
         cyc(vecs[i].allow, vecs[i].br, vecs[i].tgt, vecs[i].aok, vecs[i].dok, vecs[i].rdata);
         check($sformatf("row%0d_req", i), 64'(inst_sram_req), 64'(vecs[i].e_req));
         if (vecs[i].e_req)
            check($sformatf("row%0d_addr", i), 64'(inst_sram_addr), 64'(vecs[i].e_addr));
         check($sformatf("row%0d_valid", i), 64'(fs_to_ds_valid), 64'(vecs[i].e_valid));
         if (vecs[i].e_valid)
            check($sformatf("row%0d_bus", i), fs_to_ds_bus, {vecs[i].e_inst, vecs[i].e_pc});
      end

      // Branch at D+100 with its delay slot D+104 still outstanding and the slot empty.
      cyc(1, 0, 0, 1, 0, 0);
      cyc(1, 1, D+32'h200, 0, 0, 0);
      check("b_slot_empty", 64'(fs_to_ds_valid), 64'd0);
      cyc(1, 1, D+32'h200, 0, 1, 32'h2405_0005);
      cyc(1, 1, D+32'h200, 1, 0, 0);
      chk_slot("b_delay_slot", D+32'h104, 32'h2405_0005);
      chk_req("b_target", D+32'h200);
      cyc(1, 0, 0, 0, 1, 32'h2406_0006);
      check("b_after_go", 64'(fs_to_ds_valid), 64'd0);

      // Branch held four cycles by a decode stall; target must be requested exactly once.
      watch_en = 1'b1;
      cyc(0, 1, D+32'h300, 1, 0, 0);
      chk_slot("h_start", D+32'h200, 32'h2406_0006);
      chk_req("h_start", D+32'h204);
      cyc(0, 1, D+32'h400, 0, 1, 32'hBAD0_BAD0);
      check("h_wait_req", 64'(inst_sram_req), 64'd0);
      cyc(0, 1, D+32'h400, 1, 0, 0);
      chk_req("h_target", D+32'h300);
      chk_slot("h_no_wrong_path", D+32'h200, 32'h2406_0006);
      cyc(0, 1, D+32'h400, 0, 1, 32'h2407_0007);
      cyc(1, 0, 0, 0, 0, 0);
      check("h_hold_req", 64'(inst_sram_req), 64'd0);
      cyc(1, 0, 0, 1, 0, 0);
      chk_slot("h_target_inst", D+32'h300, 32'h2407_0007);
      chk_req("h_seq", D+32'h304);
      watch_en = 1'b0;
      check("h_target_count", 64'(good_cnt), 64'd1);
      check("h_relatch_count", 64'(bad_cnt), 64'd0);

      // Reset while D+304 is outstanding; its data_ok lands during and after reset.
      @(negedge clk);
      resetn = 1'b0;
      set_in(1, 0, 0, 0, 1, 32'hBAD1_BAD1);
      #1;
      check("r_valid", 64'(fs_to_ds_valid), 64'd0);
      check("r_req", 64'(inst_sram_req), 64'd0);
      @(negedge clk);
      #1;
      check("r_valid_hold", 64'(fs_to_ds_valid), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk_req("r_refetch", D);
      cyc(1, 0, 0, 1, 0, 0);
      check("r_late_dok", 64'(fs_to_ds_valid), 64'd0);
      chk_req("r_refetch_hold", D);
      cyc(1, 0, 0, 0, 1, 32'h2408_0008);
      check("r_wait_req", 64'(inst_sram_req), 64'd0);
      cyc(0, 0, 0, 0, 0, 0);
      chk_slot("r_first", D, 32'h2408_0008);
      chk_req("r_next", D+4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
